// File: rtl/key_debounce_if.sv
// Key debouncer signal bundle: raw active-low key in, debounced level and event pulses out.
interface key_debounce_if;
    logic i_key_n;
    logic o_key_level;
    logic o_press;
    logic o_release;
    logic o_long;

    // Drives the raw key and observes debounced results
    modport master (
        output i_key_n,
        input  o_key_level,
        input  o_press,
        input  o_release,
        input  o_long
    );

    // The debouncer itself
    modport slave (
        input  i_key_n,
        output o_key_level,
        output o_press,
        output o_release,
        output o_long
    );
endinterface

// File: rtl/key_debounce.sv
// Mechanical key debouncer with press/release/long-press event pulses.
// The raw key is synchronized, then qualified by a stable-sample counter;
// a separate hold counter times long presses and freezes during release checks.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned LONG_CYCLES     = 25000000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    key_debounce_if.slave bus
);

    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES) + 1;
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 32'd1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_CHK,
        PRESSED,
        LONG_HELD,
        RELEASE_CHK
    } state_t;

    state_t            state_q,     state_d;
    logic [DEB_W-1:0]  deb_cnt_q,   deb_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
    logic [1:0]        key_sync_q,  key_sync_d;
    logic              was_long_q,  was_long_d;
    logic              key_level_q, key_level_d;
    logic              press_q,     press_d;
    logic              release_q,   release_d;
    logic              long_q,      long_d;
    logic              key_s;

    assign key_s = key_sync_q[1];

    // State, counters, synchronizer and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            key_sync_q  <= 2'b11;
            was_long_q  <= 1'b0;
            key_level_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            key_sync_q  <= key_sync_d;
            was_long_q  <= was_long_d;
            key_level_q <= key_level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    // Next-state, counter and event-pulse logic
    always_comb begin
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        hold_cnt_d = hold_cnt_q;
        was_long_d = was_long_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        key_sync_d = {key_sync_q[0], bus.i_key_n};

        case (state_q)
            IDLE: begin
                if (!key_s) begin
                    state_d   = PRESS_CHK;
                    deb_cnt_d = '0;
                end
            end
            PRESS_CHK: begin
                // A high sample wins even on the terminal-count edge
                if (key_s) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d    = PRESSED;
                    press_d    = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            PRESSED: begin
                if (key_s) begin
                    state_d    = RELEASE_CHK;
                    deb_cnt_d  = '0;
                    was_long_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = LONG_HELD;
                        long_d  = 1'b1;
                    end
                end
            end
            LONG_HELD: begin
                // Hold counter stays put so o_long cannot fire again
                if (key_s) begin
                    state_d    = RELEASE_CHK;
                    deb_cnt_d  = '0;
                    was_long_d = 1'b1;
                end
            end
            RELEASE_CHK: begin
                // Hold counter frozen; a bounce resumes the recorded held state
                if (!key_s) begin
                    state_d = was_long_q ? LONG_HELD : PRESSED;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        key_level_d = (state_d == PRESSED) || (state_d == LONG_HELD) ||
                      (state_d == RELEASE_CHK);
    end

    assign bus.o_key_level = key_level_q;
    assign bus.o_press     = press_q;
    assign bus.o_release   = release_q;
    assign bus.o_long      = long_q;

endmodule
